mw_control: RTL and testbench
=============================

// Module: mw_control
// PURPOSE
//  Memory/writeback (MW) stage control decoder for the 3-stage RV32I pipeline.
//  - Decodes the MW-stage instruction's opcode, funct3 and CSR address.
//  - Outputs: base store byte mask, data-memory read enable, writeback mux select,
//    regfile write enable, and the tohost CSR write enable.
//  - Stateless combinational decode; clock and reset ports keep the stage interface uniform.
// PARAMETERS
//  CSR_TOHOST  12'h51E  CSR address whose write raises csr_we
// PORTS
//  clk     in   1   stage clock (no state uses it)
//  rst     in   1   synchronous active-high reset (no effect; block holds no state)
//  opcode  in   7   instruction[6:0] in MW stage
//  funct3  in   3   instruction[14:12] in MW stage
//  csr     in   12  instruction[31:20] (CSR address field)
//  w_mask  out  4   base (unshifted) byte write mask; 0 = no store
//  re      out  1   data-memory read enable (loads)
//  wb_sel  out  2   writeback select: 00 mem data, 01 ALU result, 10 PC+4
//  rwe     out  1   register-file write enable
//  csr_we  out  1   CSR write enable (tohost)
// BEHAVIOUR
//  - One clock and one synchronous, active-high reset.
//  - All outputs are purely combinational functions of opcode/funct3/csr; latency 0.
//  - No registers, so there is no reset value.
//    Outputs follow the inputs during and after rst.
//  - Default, for any unlisted or illegal opcode: w_mask=0000, re=0, wb_sel=01, rwe=0, csr_we=0.
//  - Every output is always driven to 0/1, never X.
//  Decode by opcode (outputs not listed take their default):
//  - LOAD   7'b0000011: re=1, wb_sel=00, rwe=1 (all funct3; LB/LH/LW/LBU/LHU).
//  - STORE  7'b0100011: w_mask by funct3:
//    - 000 (SB) -> 0001
//    - 001 (SH) -> 0011
//    - 010 (SW) -> 1111
//    - any other funct3 -> 0000
//    - rwe=0, re=0.
//  - OP     7'b0110011, OP-IMM 7'b0010011, LUI 7'b0110111, AUIPC 7'b0010111:
//    rwe=1, wb_sel=01.
//  - JAL    7'b1101111, JALR 7'b1100111: rwe=1, wb_sel=10.
//  - BRANCH 7'b1100011: rwe=0, wb_sel=01.
//  - SYSTEM 7'b1110011:
//    - csr_we=1 iff funct3 is 001 (CSRRW) or 101 (CSRRWI) AND csr==CSR_TOHOST.
//    - Other CSR ops, other addresses, ECALL/EBREAK (funct3=000) -> csr_we=0.
//    - rwe=0 (no readable CSRs), wb_sel=01.
//  - w_mask is nonzero only for STORE. Shifting by address offset is done downstream.
//  - re=1 only for LOAD; rwe and csr_we are never both 1.
//  - rd==x0 is not visible here; the register file ignores x0 writes.
// TESTING
//  - LOAD, funct3=010 -> w_mask=0000, re=1, wb_sel=00, rwe=1, csr_we=0.
//  - STORE, funct3=000/001/010/011 -> w_mask=0001/0011/1111/0000; re=0, rwe=0, csr_we=0.
//  - OP and OP-IMM (any funct3), LUI, AUIPC -> rwe=1, wb_sel=01, re=0, w_mask=0000.
//  - JAL, JALR -> rwe=1, wb_sel=10; BRANCH (any funct3) -> rwe=0, w_mask=0000, re=0.
//  - SYSTEM csr=51E:
//    - funct3=001 -> csr_we=1; funct3=101 -> csr_we=1.
//    - funct3=010 -> csr_we=0.
//    - csr=300 with funct3=001 -> csr_we=0.
//    - rwe=0 in all four cases.
//  - Opcode 7'b0000000 and 7'b1111111, with rst toggled high then low:
//    all outputs equal the default, with no X on any output.

Source files
------------

// File: rtl/mw_control.sv
// MW-stage control decoder: turns the opcode/funct3/CSR fields of the instruction
// in memory/writeback into store mask, load enable, writeback select and write enables.
module mw_control #(
    parameter logic [11:0] CSR_TOHOST = 12'h51E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr,
    output logic [3:0]  w_mask,
    output logic        re,
    output logic [1:0]  wb_sel,
    output logic        rwe,
    output logic        csr_we
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Clock and reset exist only to keep the stage interface uniform.
    logic unused_stage_ports;
    assign unused_stage_ports = &{1'b0, clk, rst};

    always_comb begin
        w_mask = 4'b0000;
        re     = 1'b0;
        wb_sel = WB_ALU;
        rwe    = 1'b0;
        csr_we = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                re     = 1'b1;
                wb_sel = WB_MEM;
                rwe    = 1'b1;
            end
            OPC_STORE: begin
                // Unshifted mask; byte-lane alignment happens downstream.
                case (funct3)
                    3'b000:  w_mask = 4'b0001;
                    3'b001:  w_mask = 4'b0011;
                    3'b010:  w_mask = 4'b1111;
                    default: w_mask = 4'b0000;
                endcase
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                rwe = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                rwe    = 1'b1;
                wb_sel = WB_PC4;
            end
            OPC_SYSTEM: begin
                // Only CSRRW/CSRRWI to tohost are visible; no CSR is readable.
                csr_we = ((funct3 == 3'b001) || (funct3 == 3'b101))
                         && (csr == CSR_TOHOST);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mw_control.sv
// Scoreboard bench for mw_control: each applied vector queues its expected
// decode, which is popped and compared once the outputs have settled.
module tb_mw_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = 7'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [11:0] csr = 12'h0;
    logic [3:0]  w_mask;
    logic        re;
    logic [1:0]  wb_sel;
    logic        rwe;
    logic        csr_we;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] wm;
        logic       re;
        logic [1:0] wb;
        logic       rwe;
        logic       cwe;
    } exp_t;

    exp_t sb[$];

    mw_control #(.CSR_TOHOST(12'h51E)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .funct3 (funct3),
        .csr    (csr),
        .w_mask (w_mask),
        .re     (re),
        .wb_sel (wb_sel),
        .rwe    (rwe),
        .csr_we (csr_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decode written as a table of opcode classes.
    function automatic exp_t model(input string tag, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [11:0] c);
        exp_t e;
        e.tag = tag;
        e.wm  = 4'b0000;
        e.re  = 1'b0;
        e.wb  = 2'b01;
        e.rwe = 1'b0;
        e.cwe = 1'b0;
        if (op == 7'h03) begin
            e.re  = 1'b1;
            e.wb  = 2'b00;
            e.rwe = 1'b1;
        end else if (op == 7'h23) begin
            if (f3 == 3'd0)      e.wm = 4'h1;
            else if (f3 == 3'd1) e.wm = 4'h3;
            else if (f3 == 3'd2) e.wm = 4'hF;
        end else if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17) begin
            e.rwe = 1'b1;
        end else if (op == 7'h6F || op == 7'h67) begin
            e.rwe = 1'b1;
            e.wb  = 2'b10;
        end else if (op == 7'h73) begin
            e.cwe = (c == 12'h51E) && (f3 == 3'd1 || f3 == 3'd5);
        end
        return e;
    endfunction

    task automatic compare_one();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".w_mask"}, {28'd0, w_mask}, {28'd0, e.wm});
        check({e.tag, ".re"},     {31'd0, re},     {31'd0, e.re});
        check({e.tag, ".wb_sel"}, {30'd0, wb_sel}, {30'd0, e.wb});
        check({e.tag, ".rwe"},    {31'd0, rwe},    {31'd0, e.rwe});
        check({e.tag, ".csr_we"}, {31'd0, csr_we}, {31'd0, e.cwe});
        check({e.tag, ".excl"},   {31'd0, rwe & csr_we}, 32'd0);
        check({e.tag, ".no_x"},
              {31'd0, $isunknown({w_mask, re, wb_sel, rwe, csr_we})}, 32'd0);
    endtask

    task automatic apply(input string tag, input logic [6:0] op,
                         input logic [2:0] f3, input logic [11:0] c);
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        csr    = c;
        sb.push_back(model(tag, op, f3, c));
        @(posedge clk);
        #1;
        compare_one();
    endtask

    logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37,
                             7'h17, 7'h6F, 7'h67, 7'h63, 7'h73};

    initial begin
        // Defaults on illegal opcodes while reset is asserted, then released.
        rst = 1'b1;
        apply("ill00_rst", 7'b0000000, 3'd0, 12'h000);
        apply("load_rst",  7'b0000011, 3'd2, 12'h000);
        apply("ill7f_rst", 7'b1111111, 3'd7, 12'hFFF);
        rst = 1'b0;
        apply("ill00",     7'b0000000, 3'd0, 12'h000);
        apply("ill7f",     7'b1111111, 3'd7, 12'hFFF);

        apply("lw",     7'h03, 3'd2, 12'h000);
        apply("lbu",    7'h03, 3'd4, 12'h51E);
        apply("sb",     7'h23, 3'd0, 12'h000);
        apply("sh",     7'h23, 3'd1, 12'h000);
        apply("sw",     7'h23, 3'd2, 12'h000);
        apply("s011",   7'h23, 3'd3, 12'h000);
        apply("op",     7'h33, 3'd5, 12'h000);
        apply("opimm",  7'h13, 3'd7, 12'h000);
        apply("lui",    7'h37, 3'd0, 12'h000);
        apply("auipc",  7'h17, 3'd3, 12'h000);
        apply("jal",    7'h6F, 3'd0, 12'h000);
        apply("jalr",   7'h67, 3'd0, 12'h000);
        apply("branch", 7'h63, 3'd1, 12'h000);
        apply("csrrw",  7'h73, 3'd1, 12'h51E);
        apply("csrrwi", 7'h73, 3'd5, 12'h51E);
        apply("csrrs",  7'h73, 3'd2, 12'h51E);
        apply("csr300", 7'h73, 3'd1, 12'h300);
        apply("csr51f", 7'h73, 3'd1, 12'h51F);
        apply("ecall",  7'h73, 3'd0, 12'h000);

        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            logic [11:0] c;
            op = (i % 4 == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            c  = ($urandom_range(0, 1) == 1) ? 12'h51E : 12'($urandom);
            apply($sformatf("rnd%0d", i), op, 3'($urandom), c);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
